// File: rtl/csr_pkg.sv
// Shared encodings for the machine-mode CSR / trap unit: CSR addresses,
// access op codes, interrupt cause codes and mstatus bit positions.
package csr_pkg;

   localparam logic [1:0] CSR_OP_NONE = 2'b00;
   localparam logic [1:0] CSR_OP_RW   = 2'b01;
   localparam logic [1:0] CSR_OP_RS   = 2'b10;
   localparam logic [1:0] CSR_OP_RC   = 2'b11;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam logic [3:0] IRQ_MSI = 4'd3;
   localparam logic [3:0] IRQ_MTI = 4'd7;
   localparam logic [3:0] IRQ_MEI = 4'd11;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   // Read-modify-write result of a CSR op, computed at 64 bits and truncated by the caller.
   function automatic logic [63:0] csr_apply(input logic [1:0] op, input logic [63:0] old_v,
                                             input logic [63:0] wd);
      case (op)
         CSR_OP_RS: return old_v | wd;
         CSR_OP_RC: return old_v & ~wd;
         default:   return wd;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with independently writable halves; a write to
// either half takes precedence over the increment in the same cycle.
module csr_counter64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [63:0] wdata,
   output logic [63:0] count
);

   logic [63:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (wr_lo || wr_hi) begin
         if (wr_lo) count_d[31:0]  = wdata[31:0];
         if (wr_hi) count_d[63:32] = wdata[63:32];
      end else if (inc) begin
         count_d = count_q + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with synchronous exception / interrupt entry and mret.
// Event priority in one cycle: exception > interrupt at boundary > mret > CSR write.
module csr_trap_unit
   import csr_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] MTVEC_RST = '0,
   parameter logic [XLEN-1:0] HART_ID   = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            csr_valid,
   input  logic [1:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            exc_valid,
   input  logic [3:0]      exc_code,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            mret,
   input  logic            retire,
   input  logic            boundary,
   input  logic [XLEN-1:0] boundary_pc,
   input  logic            irq_sw,
   input  logic            irq_timer,
   input  logic            irq_ext,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            irq_taken
);

   logic            st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
   logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
   logic [XLEN-1:0] mstatus_v, misa_v, mip_v, mtvec_base, csr_new;
   logic [63:0]     cyc_cnt, ins_cnt, cnt_wdata;
   logic            addr_ok, read_only, wr_req, do_csr_wr, irq_pend, trap_irq;
   logic            cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
   logic [3:0]      irq_code;

   always_comb begin
      mstatus_v = '0;
      mstatus_v[MSTATUS_MIE]  = st_mie_q;
      mstatus_v[MSTATUS_MPIE] = st_mpie_q;
      mstatus_v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      misa_v = '0;
      misa_v[8]  = 1'b1;
      misa_v[12] = 1'b1;
      misa_v[XLEN-1:XLEN-2] = (XLEN == 64) ? 2'b10 : 2'b01;
      mip_v = '0;
      mip_v[3]  = irq_sw;
      mip_v[7]  = irq_timer;
      mip_v[11] = irq_ext;
   end

   always_comb begin
      csr_rdata = '0;
      addr_ok   = 1'b1;
      case (csr_addr)
         CSR_MSTATUS:   csr_rdata = mstatus_v;
         CSR_MISA:      csr_rdata = misa_v;
         CSR_MIE:       csr_rdata = mie_q;
         CSR_MTVEC:     csr_rdata = mtvec_q;
         CSR_MSCRATCH:  csr_rdata = mscratch_q;
         CSR_MEPC:      csr_rdata = mepc_q;
         CSR_MCAUSE:    csr_rdata = mcause_q;
         CSR_MTVAL:     csr_rdata = mtval_q;
         CSR_MIP:       csr_rdata = mip_v;
         CSR_MHARTID:   csr_rdata = HART_ID;
         CSR_MCYCLE:    csr_rdata = XLEN'(cyc_cnt);
         CSR_MINSTRET:  csr_rdata = XLEN'(ins_cnt);
         CSR_MCYCLEH:   begin
            csr_rdata = XLEN'(cyc_cnt[63:32]);
            addr_ok   = (XLEN == 32);
         end
         CSR_MINSTRETH: begin
            csr_rdata = XLEN'(ins_cnt[63:32]);
            addr_ok   = (XLEN == 32);
         end
         default:       addr_ok = 1'b0;
      endcase
   end

   // RS/RC with a zero operand is a pure read, so it is legal even on read-only CSRs.
   assign read_only = (csr_addr == CSR_MISA) || (csr_addr == CSR_MIP) ||
                      (csr_addr == CSR_MHARTID) || (csr_addr[11:10] == 2'b11);
   assign wr_req    = csr_valid && (csr_op != CSR_OP_NONE) &&
                      ((csr_op == CSR_OP_RW) || (csr_wdata != '0));
   assign csr_illegal = !rst && csr_valid && (csr_op != CSR_OP_NONE) &&
                        (!addr_ok || (wr_req && read_only));
   assign csr_new = XLEN'(csr_apply(csr_op, 64'(csr_rdata), 64'(csr_wdata)));

   assign irq_pend = st_mie_q && ((mie_q & mip_v) != '0);
   assign trap_irq = !rst && !exc_valid && boundary && irq_pend;
   assign do_csr_wr = !rst && wr_req && addr_ok && !read_only && !exc_valid && !trap_irq && !mret;

   always_comb begin
      if (mie_q[11] && irq_ext)      irq_code = IRQ_MEI;
      else if (mie_q[3] && irq_sw)   irq_code = IRQ_MSI;
      else                           irq_code = IRQ_MTI;
   end

   assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
   assign redirect   = !rst && (exc_valid || trap_irq || mret);
   assign irq_taken  = trap_irq;

   always_comb begin
      redirect_pc = '0;
      if (exc_valid)                  redirect_pc = mtvec_base;
      else if (trap_irq && mtvec_q[0]) redirect_pc = mtvec_base + XLEN'({irq_code, 2'b00});
      else if (trap_irq)              redirect_pc = mtvec_base;
      else if (mret)                  redirect_pc = mepc_q;
   end

   always_comb begin
      st_mie_d   = st_mie_q;
      st_mpie_d  = st_mpie_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      cyc_wr_lo  = 1'b0;
      cyc_wr_hi  = 1'b0;
      ins_wr_lo  = 1'b0;
      ins_wr_hi  = 1'b0;
      cnt_wdata  = (XLEN == 64) ? 64'(csr_new) : {2{csr_new[31:0]}};
      if (exc_valid || trap_irq) begin
         mepc_d   = (exc_valid ? exc_pc : boundary_pc) & ~XLEN'(3);
         mcause_d = '0;
         mcause_d[XLEN-1] = trap_irq;
         mcause_d[3:0]    = trap_irq ? irq_code : exc_code;
         mtval_d   = exc_valid ? exc_tval : '0;
         st_mpie_d = st_mie_q;
         st_mie_d  = 1'b0;
      end else if (mret) begin
         st_mie_d  = st_mpie_q;
         st_mpie_d = 1'b1;
      end else if (do_csr_wr) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               st_mie_d  = csr_new[MSTATUS_MIE];
               st_mpie_d = csr_new[MSTATUS_MPIE];
            end
            CSR_MIE:       mie_d = csr_new & XLEN'(12'h888);
            CSR_MTVEC:     mtvec_d = csr_new & ~XLEN'(2);
            CSR_MSCRATCH:  mscratch_d = csr_new;
            CSR_MEPC:      mepc_d = csr_new & ~XLEN'(3);
            CSR_MCAUSE:    mcause_d = csr_new;
            CSR_MTVAL:     mtval_d = csr_new;
            CSR_MCYCLE:    begin cyc_wr_lo = 1'b1; cyc_wr_hi = (XLEN == 64); end
            CSR_MINSTRET:  begin ins_wr_lo = 1'b1; ins_wr_hi = (XLEN == 64); end
            CSR_MCYCLEH:   cyc_wr_hi = 1'b1;
            CSR_MINSTRETH: ins_wr_hi = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_mie_q   <= 1'b0;
         st_mpie_q  <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RST;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else begin
         st_mie_q   <= st_mie_d;
         st_mpie_q  <= st_mpie_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
      end
   end

   csr_counter64 u_mcycle (
      .clk(clk), .rst(rst), .inc(1'b1), .wr_lo(cyc_wr_lo), .wr_hi(cyc_wr_hi),
      .wdata(cnt_wdata), .count(cyc_cnt)
   );

   csr_counter64 u_minstret (
      .clk(clk), .rst(rst), .inc(retire), .wr_lo(ins_wr_lo), .wr_hi(ins_wr_hi),
      .wdata(cnt_wdata), .count(ins_cnt)
   );

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit (XLEN=32): CSR ops, masking, traps, mret,
// counters and reset priority, checked against hand-computed values.
module tb_csr_trap_unit;
   import csr_pkg::*;

   logic        clk, rst;
   logic        csr_valid;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, csr_rdata;
   logic        csr_illegal;
   logic        exc_valid;
   logic [3:0]  exc_code;
   logic [31:0] exc_pc, exc_tval;
   logic        mret, retire, boundary;
   logic [31:0] boundary_pc;
   logic        irq_sw, irq_timer, irq_ext;
   logic        redirect, irq_taken;
   logic [31:0] redirect_pc;

   int n_tests = 0;
   int n_fail  = 0;

   csr_trap_unit #(.XLEN(32), .MTVEC_RST(32'h0), .HART_ID(32'h0)) dut (
      .clk(clk), .rst(rst),
      .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .mret(mret), .retire(retire), .boundary(boundary), .boundary_pc(boundary_pc),
      .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
      .redirect(redirect), .redirect_pc(redirect_pc), .irq_taken(irq_taken)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_events();
      csr_valid = 1'b0; csr_op = CSR_OP_NONE; csr_addr = '0; csr_wdata = '0;
      exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_tval = '0;
      mret = 1'b0; retire = 1'b0; boundary = 1'b0; boundary_pc = '0;
   endtask

   // One CSR access: driven at negedge, sampled before the commit edge.
   task automatic csr_do(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic ill);
      @(negedge clk);
      csr_valid = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
      #1;
      rd  = csr_rdata;
      ill = csr_illegal;
      @(posedge clk);
      #1 clear_events();
   endtask

   task automatic csr_wr(input logic [11:0] addr, input logic [31:0] wd);
      logic [31:0] rd;
      logic ill;
      csr_do(CSR_OP_RW, addr, wd, rd, ill);
   endtask

   task automatic csr_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      logic ill;
      csr_do(CSR_OP_RS, addr, 32'h0, rd, ill);
      check_val(tag, rd, exp);
   endtask

   // Caller has set the event inputs after a negedge; check redirect outputs, then commit.
   task automatic event_chk(input string tag, input logic exp_redir, input logic [31:0] exp_pc,
                            input logic exp_irq);
      #1;
      check_val({tag, "_redirect"}, redirect, exp_redir);
      if (exp_redir) check_val({tag, "_pc"}, redirect_pc, exp_pc);
      check_val({tag, "_irq_taken"}, irq_taken, exp_irq);
      @(posedge clk);
      #1 clear_events();
   endtask

   initial begin
      logic [31:0] rd;
      logic ill;
      clear_events();
      irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      csr_chk("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
      csr_chk("rst_misa", CSR_MISA, 32'h4000_1100);
      csr_chk("rst_mtvec", CSR_MTVEC, 32'h0);
      csr_chk("rst_mcause", CSR_MCAUSE, 32'h0);
      csr_chk("rst_mhartid", CSR_MHARTID, 32'h0);
      check_val("rst_redirect", redirect, 1'b0);

      // RS / RC on mscratch
      csr_wr(CSR_MSCRATCH, 32'hF0);
      csr_do(CSR_OP_RS, CSR_MSCRATCH, 32'h0F, rd, ill);
      check_val("rs_old_rdata", rd, 32'hF0);
      check_val("rs_legal", ill, 1'b0);
      csr_chk("rs_result", CSR_MSCRATCH, 32'hFF);
      csr_do(CSR_OP_RC, CSR_MSCRATCH, 32'h0, rd, ill);
      csr_chk("rc_zero_nochange", CSR_MSCRATCH, 32'hFF);
      csr_do(CSR_OP_RC, CSR_MSCRATCH, 32'h0F, rd, ill);
      csr_chk("rc_clear", CSR_MSCRATCH, 32'hF0);
      csr_wr(CSR_MSCRATCH, 32'hFF);

      // write masking
      csr_wr(CSR_MSTATUS, 32'hFFFF_FFFF);
      csr_chk("mstatus_mask", CSR_MSTATUS, 32'h0000_1888);
      csr_wr(CSR_MIE, 32'hFFFF_FFFF);
      csr_chk("mie_mask", CSR_MIE, 32'h0000_0888);
      csr_wr(CSR_MEPC, 32'h0000_FFFF);
      csr_chk("mepc_mask", CSR_MEPC, 32'h0000_FFFC);
      csr_wr(CSR_MTVEC, 32'h0000_0103);
      csr_chk("mtvec_mask", CSR_MTVEC, 32'h0000_0101);
      csr_wr(CSR_MIE, 32'h0);

      // illegal accesses
      csr_do(CSR_OP_RW, CSR_MHARTID, 32'h5, rd, ill);
      check_val("mhartid_wr_illegal", ill, 1'b1);
      csr_chk("mhartid_unchanged", CSR_MHARTID, 32'h0);
      csr_do(CSR_OP_RS, 12'h7C0, 32'h0, rd, ill);
      check_val("unlisted_illegal", ill, 1'b1);
      csr_do(CSR_OP_RS, CSR_MISA, 32'h0, rd, ill);
      check_val("misa_read_legal", ill, 1'b0);
      csr_do(CSR_OP_RS, CSR_MIP, 32'h8, rd, ill);
      check_val("mip_set_illegal", ill, 1'b1);

      // synchronous exception
      csr_wr(CSR_MTVEC, 32'h100);
      csr_wr(CSR_MSTATUS, 32'h8);
      @(negedge clk);
      exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'h8000_0010; exc_tval = 32'h13;
      event_chk("exc", 1'b1, 32'h100, 1'b0);
      csr_chk("exc_mepc", CSR_MEPC, 32'h8000_0010);
      csr_chk("exc_mcause", CSR_MCAUSE, 32'h2);
      csr_chk("exc_mtval", CSR_MTVAL, 32'h13);
      csr_chk("exc_mstatus", CSR_MSTATUS, 32'h0000_1880);

      // mret restores MIE
      @(negedge clk);
      mret = 1'b1;
      event_chk("mret1", 1'b1, 32'h8000_0010, 1'b0);
      csr_chk("mret1_mstatus", CSR_MSTATUS, 32'h0000_1888);

      // vectored timer interrupt
      csr_wr(CSR_MTVEC, 32'h101);
      csr_wr(CSR_MIE, 32'h80);
      irq_timer = 1'b1;
      @(negedge clk);
      boundary = 1'b1; boundary_pc = 32'h200;
      event_chk("mti", 1'b1, 32'h11C, 1'b1);
      csr_chk("mti_mcause", CSR_MCAUSE, 32'h8000_0007);
      csr_chk("mti_mepc", CSR_MEPC, 32'h200);
      csr_chk("mti_mtval", CSR_MTVAL, 32'h0);
      csr_chk("mti_mip", CSR_MIP, 32'h80);
      @(negedge clk);
      boundary = 1'b1; boundary_pc = 32'h204;
      event_chk("mie_off", 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      mret = 1'b1;
      event_chk("mret2", 1'b1, 32'h200, 1'b0);

      // external beats timer
      csr_wr(CSR_MIE, 32'h880);
      irq_ext = 1'b1;
      @(negedge clk);
      boundary = 1'b1; boundary_pc = 32'h300;
      event_chk("mei", 1'b1, 32'h12C, 1'b1);
      csr_chk("mei_mcause", CSR_MCAUSE, 32'h8000_000B);
      @(negedge clk);
      mret = 1'b1;
      event_chk("mret3", 1'b1, 32'h300, 1'b0);

      // exception beats interrupt and drops the same-cycle CSR write
      @(negedge clk);
      exc_valid = 1'b1; exc_code = 4'd5; exc_pc = 32'h400; exc_tval = 32'h99;
      boundary = 1'b1; boundary_pc = 32'h404;
      csr_valid = 1'b1; csr_op = CSR_OP_RW; csr_addr = CSR_MSCRATCH; csr_wdata = 32'h1234;
      event_chk("exc_vs_irq", 1'b1, 32'h100, 1'b0);
      irq_ext = 1'b0; irq_timer = 1'b0;
      csr_chk("exc_vs_irq_mcause", CSR_MCAUSE, 32'h5);
      csr_chk("exc_vs_irq_mepc", CSR_MEPC, 32'h400);
      csr_chk("csr_write_dropped", CSR_MSCRATCH, 32'hFF);

      // counters: carry into mcycleh, write beats increment
      csr_wr(CSR_MCYCLEH, 32'h0);
      csr_wr(CSR_MCYCLE, 32'hFFFF_FFFF);
      csr_chk("mcycle_lo_max", CSR_MCYCLE, 32'hFFFF_FFFF);
      csr_chk("mcycleh_carry", CSR_MCYCLEH, 32'h1);
      csr_chk("mcycle_wrapped", CSR_MCYCLE, 32'h1);
      csr_wr(CSR_MCYCLE, 32'h5);
      csr_chk("mcycle_wr_wins", CSR_MCYCLE, 32'h5);
      csr_chk("mcycleh_kept", CSR_MCYCLEH, 32'h1);
      csr_wr(CSR_MINSTRET, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         retire = 1'b1;
         @(posedge clk);
         #1 clear_events();
      end
      csr_chk("minstret_count", CSR_MINSTRET, 32'h3);

      // reset wins over same-cycle events
      @(negedge clk);
      rst = 1'b1;
      exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'h500;
      csr_valid = 1'b1; csr_op = CSR_OP_RW; csr_addr = CSR_MHARTID; csr_wdata = 32'h1;
      #1;
      check_val("rst_no_redirect", redirect, 1'b0);
      check_val("rst_no_illegal", csr_illegal, 1'b0);
      @(posedge clk);
      #1 clear_events();
      rst = 1'b0;
      csr_chk("rst2_mscratch", CSR_MSCRATCH, 32'h0);
      csr_chk("rst2_mcause", CSR_MCAUSE, 32'h0);
      csr_chk("rst2_mtvec", CSR_MTVEC, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter MTVEC_RST, default 0, mtvec reset value.
REQ-003 SHALL have parameter HART_ID, default 0, value returned by mhartid.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-005 SHALL have ports: csr_valid in 1 CSR access; csr_op in 2 CSR op (01 RW, 10 RS, 11 RC, 00 none); csr_addr in 12 CSR address; csr_wdata in XLEN write operand.
REQ-006 SHALL have ports: csr_rdata out XLEN old CSR value (combinational); csr_illegal out 1 access rejected.
REQ-007 SHALL have ports: exc_valid in 1 synchronous exception; exc_code in 4 cause; exc_pc in XLEN faulting PC; exc_tval in XLEN trap value.
REQ-008 SHALL have ports: mret in 1 return; retire in 1 instruction retired; boundary in 1 interrupt may be taken; boundary_pc in XLEN next PC.
REQ-009 SHALL have ports: irq_sw, irq_timer, irq_ext in 1 each, level interrupt lines.
REQ-010 SHALL have ports: redirect out 1 PC redirect; redirect_pc out XLEN target; irq_taken out 1 redirect is an interrupt.

Function
REQ-011 SHALL implement mstatus (MIE b3, MPIE b7, MPP b12:11 fixed 11), misa, mie, mip, mtvec, mscratch, mepc, mcause, mtval, mhartid, mcycle, minstret; when XLEN=32, also mcycleh and minstreth.
REQ-012 SHALL treat access as legal only for listed addresses; RS/RC with csr_wdata=0 never writes.
REQ-013 SHALL flag csr_illegal, with no state change, for an unlisted address, or for a writing op to mhartid, misa, mip, or addr[11:10]=11.
REQ-014 SHALL commit CSR writes at the next clk edge; RW=wdata, RS=old|wdata, RC=old&~wdata; csr_rdata is the pre-write value.
REQ-015 SHALL mask writes: mstatus only MIE/MPIE writable; mie only bits 3/7/11; mtvec bit1 reads 0; mepc bits1:0 read 0.
REQ-016 SHALL reflect mip bits 3/7/11 combinationally from irq_sw/irq_timer/irq_ext.
REQ-017 SHALL define an interrupt as pending when mstatus.MIE and (mie&mip) is nonzero; priority MEI(11) > MSI(3) > MTI(7).
REQ-018 SHALL apply event priority exc_valid > pending interrupt at boundary > mret > CSR write; a lower event in the same cycle is suppressed, including its csr write.
REQ-019 SHALL on trap, same edge: mepc=exc_pc or boundary_pc; mcause = {irq bit XLEN-1, code}; mtval = exc_tval, or 0 for an interrupt; MPIE=MIE; MIE=0.
REQ-020 SHALL drive redirect combinationally in the trap cycle; redirect_pc = mtvec base when MODE=0 or on an exception, else base+4*code for an interrupt.
REQ-021 SHALL on mret: redirect=1, redirect_pc=mepc, MIE=MPIE, MPIE=1.
REQ-022 SHALL increment 64-bit mcycle every cycle and minstret on retire; a CSR write to either half wins over the increment that cycle; carry crosses 32 bits.
REQ-023 SHALL keep redirect, irq_taken, and csr_illegal at 0 unless their event is present.

Reset
REQ-024 SHALL on rst clear mstatus (MPP=11), mie, mepc, mcause, mtval, mscratch, and counters; set mtvec=MTVEC_RST; misa = RV32I/RV64I+M.
REQ-025 SHALL let rst win over every same-cycle event: no trap, no write, no redirect.

Structure
REQ-026 SHALL place CSR addresses, op encodings, cause codes, and mstatus bit indices in shared package csr_pkg.
REQ-027 SHALL instantiate sub-module csr_counter64 twice (mcycle, minstret); it has inc, wr_lo, wr_hi, and wdata.

Verification
REQ-028 SHALL cover: RS mscratch=0xF0, wdata=0x0F -> rdata 0xF0, next read 0xFF; RC with wdata=0 -> no change.
REQ-029 SHALL cover: exc_valid code 2, pc 0x80000010, tval 0x13, MIE=1 -> redirect_pc=mtvec, mepc 0x80000010, mcause 2, MIE 0, MPIE 1.
REQ-030 SHALL cover: mtvec=0x100|1, mie=0x80, MIE=1, irq_timer, boundary_pc 0x200 -> redirect_pc 0x11C, mcause 0x80000007, mepc 0x200.
REQ-031 SHALL cover: irq_ext and irq_timer together, both enabled -> cause 11; the same cycle with exc_valid -> exception taken, csr write dropped.
REQ-032 SHALL cover: mcycle=0xFFFFFFFF, XLEN=32 -> next mcycleh +1, mcycle 0; write mcycle=5 with inc -> reads 5.
REQ-033 SHALL cover: write mhartid -> csr_illegal=1, no change; mret after trap -> redirect_pc=mepc, MIE restored 1.
